// File: rtl/reu_ram_arb.sv
// Memory arbiter sharing one RAM port between the system bus, the REU DMA engine and
// refresh, using fixed 4-clock windows separated by a single gap clock.
module reu_ram_arb #(
    parameter int RFS_INT = 384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reu_active,
    output logic        reu_cycle,
    input  logic [24:0] reu_addr,
    input  logic [7:0]  reu_dout,
    input  logic        reu_we,
    output logic [7:0]  reu_din,
    input  logic        sys_req,
    input  logic [24:0] sys_addr,
    input  logic [7:0]  sys_dout,
    input  logic        sys_we,
    output logic [7:0]  sys_din,
    output logic        sys_ack,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_rfs
);

    typedef enum logic [2:0] {IDLE, WIN_SYS, WIN_REU, WIN_RFS, GAP} state_t;

    localparam logic [15:0] RFS_RELOAD = 16'(RFS_INT - 1);

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic        last_reu_q, last_reu_d;
    logic        rfs_pend_q;
    logic [15:0] rfs_cnt_q;
    logic        mem_ce_q, mem_we_q, mem_rfs_q;
    logic [24:0] mem_addr_q;
    logic [7:0]  mem_dout_q;
    logic [7:0]  reu_din_q, sys_din_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= 2'd0;
            last_reu_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            last_reu_q <= last_reu_d;
        end
    end

    // Refresh beats both requesters; a SYS/REU tie goes to whoever was not granted last.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        last_reu_d = last_reu_q;
        case (state_q)
            IDLE: begin
                phase_d = 2'd0;
                if (rfs_pend_q) begin
                    state_d = WIN_RFS;
                end else if (sys_req && (!reu_active || last_reu_q)) begin
                    state_d    = WIN_SYS;
                    last_reu_d = 1'b0;
                end else if (reu_active) begin
                    state_d    = WIN_REU;
                    last_reu_d = 1'b1;
                end
            end
            WIN_SYS, WIN_REU, WIN_RFS: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    state_d = GAP;
                    phase_d = 2'd0;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reu_cycle = (state_q == WIN_REU);
        sys_ack   = (state_q == WIN_SYS) && (phase_q == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rfs_cnt_q  <= RFS_RELOAD;
            rfs_pend_q <= 1'b0;
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_rfs_q  <= 1'b0;
            mem_addr_q <= 25'd0;
            mem_dout_q <= 8'd0;
            reu_din_q  <= 8'hFF;
            sys_din_q  <= 8'hFF;
        end else begin
            rfs_cnt_q <= (rfs_cnt_q == 16'd0) ? RFS_RELOAD : rfs_cnt_q - 16'd1;
            if (rfs_cnt_q == 16'd0) begin
                rfs_pend_q <= 1'b1;
            end else if (state_q == IDLE && state_d == WIN_RFS) begin
                rfs_pend_q <= 1'b0;
            end

            // Capture at the end of phase 0 so the command is presented in phase 1.
            mem_ce_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_rfs_q <= 1'b0;
            if (phase_q == 2'd0) begin
                if (state_q == WIN_SYS) begin
                    mem_ce_q   <= 1'b1;
                    mem_we_q   <= sys_we;
                    mem_addr_q <= sys_addr;
                    mem_dout_q <= sys_dout;
                end else if (state_q == WIN_REU) begin
                    mem_ce_q   <= 1'b1;
                    mem_we_q   <= reu_we;
                    mem_addr_q <= reu_addr;
                    mem_dout_q <= reu_dout;
                end else if (state_q == WIN_RFS) begin
                    mem_rfs_q <= 1'b1;
                end
            end

            if (phase_q == 2'd2) begin
                if (state_q == WIN_SYS) sys_din_q <= mem_din;
                if (state_q == WIN_REU) reu_din_q <= mem_din;
            end
        end
    end

    assign mem_ce   = mem_ce_q;
    assign mem_we   = mem_we_q;
    assign mem_rfs  = mem_rfs_q;
    assign mem_addr = mem_addr_q;
    assign mem_dout = mem_dout_q;
    assign reu_din  = reu_din_q;
    assign sys_din  = sys_din_q;

endmodule

// File: doc/reu_ram_arb.md
REU_RAM_ARB -- requirements
Module: reu_ram_arb

Interface
REQ-001 Parameter RFS_INT, default 384, is the refresh interval in clocks; legal range is 16..65535.
REQ-002 clk  in  1  the single system clock; every register updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 reu_active  in  1  REU DMA in progress (the REU dma_req level); REU windows are granted only while it is high.
REQ-005 reu_cycle  out  1  REU memory window (the REU ram_cycle input).
REQ-006 reu_addr  in  25, reu_dout  in  8, reu_we  in  1: the REU access (address, write data, write enable).
REQ-007 reu_din  out  8  REU read data.
REQ-008 sys_req  in  1  system access request; level, held until sys_ack.
REQ-009 sys_addr  in  25, sys_dout  in  8, sys_we  in  1: the system access (address, write data, write enable).
REQ-010 sys_din  out  8  system read data; sys_ack  out  1  one-clock completion pulse.
REQ-011 mem_ce  out  1, mem_we  out  1, mem_addr  out  25, mem_dout  out  8: memory command outputs.
REQ-012 mem_din  in  8  memory read data, valid in the clock after mem_ce (fixed latency 1).
REQ-013 mem_rfs  out  1  one-clock memory refresh strobe.

Function
REQ-014 States: IDLE, WIN_SYS, WIN_REU, WIN_RFS, GAP; a 2-bit phase counter counts 0..3 inside every WIN_* state.
REQ-015 Every window lasts exactly 4 clocks (phases 0..3), is never shortened or extended, and is always followed by exactly 1 GAP clock, then IDLE.
REQ-016 IDLE evaluates each clock and enters a window on the next clock, using this priority:
- rfs_pend first;
- otherwise round-robin between sys_req and reu_active;
- with a single candidate, that candidate wins.
REQ-017 The round-robin flag records the last granted of SYS and REU; on a tie the other requester wins. Refresh windows do not change the flag.
REQ-018 reu_cycle is 1 in all WIN_REU phases and 0 in every other state. This guarantees at least 1 low clock between REU windows.
REQ-019 Request capture: requester addr/we/dout are sampled on the edge ending phase 0, never earlier.
REQ-020 Phase 1 drives mem_ce=1, mem_we, mem_addr and mem_dout from the captured values.
REQ-021 mem_ce=0 and mem_we=0 in all other clocks. mem_addr/mem_dout hold their last values.
REQ-022 Read capture: mem_din is sampled on the edge ending phase 2 into reu_din (WIN_REU) or sys_din (WIN_SYS). The value is valid in phase 3 and held until the next window of the same requester. Write windows also update the respective din.
REQ-023 sys_ack=1 in phase 3 of WIN_SYS only.
REQ-024 The requester must drop sys_req within 1 clock after sys_ack. Because of the GAP clock, IDLE never sees a stale request.
REQ-025 WIN_RFS: mem_rfs=1 in phase 1 only; mem_ce stays 0.
REQ-026 Refresh counter:
- counts down every clock, including during windows;
- at 0 it sets rfs_pend and reloads RFS_INT-1;
- rfs_pend clears on entry to WIN_RFS;
- pending requests do not accumulate: at most one is outstanding.
REQ-027 If reu_active or sys_req deasserts mid-window, the window still completes with its full memory access; sys_ack still pulses.
REQ-028 If reu_active rises during a window, it is first considered in the IDLE clock following GAP.
REQ-029 reu_din and sys_din are written only in their own windows. A refresh never alters either.

Reset
REQ-030 While reset=1 (including mid-window), on the next edge:
- state=IDLE, phase=0;
- reu_cycle, sys_ack, mem_ce, mem_we, mem_rfs = 0;
- mem_addr=0, mem_dout=0;
- reu_din=sys_din=8'hFF;
- rfs_pend=0, refresh counter=RFS_INT-1;
- round-robin flag = REU-last, so SYS wins the first tie.
REQ-031 The aborted access is not acknowledged and is not retried.

Verification
REQ-032 REU read: reu_active=1, reu_addr=25'h1000010 stable, mem_din=8'h5A the clock after mem_ce.
- Response: reu_cycle high for 4 clocks; mem_ce in phase 1 with mem_addr=25'h1000010 and mem_we=0; reu_din=8'h5A in phase 3; reu_cycle low for at least 1 clock.
REQ-033 System write: sys_req=1, sys_addr=25'h0000FF0, sys_dout=8'hA5, sys_we=1.
- Response: phase 1 has mem_ce=mem_we=1 with mem_dout=8'hA5; sys_ack single pulse in phase 3; no second window once sys_req drops.
REQ-034 Contention: sys_req and reu_active both held high from reset.
- Response: window order SYS, REU, SYS, REU; each window 4 clocks plus 1 GAP.
REQ-035 Refresh: RFS_INT=16, no requests.
- Response: a WIN_RFS starts every 16 clocks, with a single mem_rfs pulse in phase 1 and no mem_ce.
- With both requesters saturating, a pending refresh is granted at the next IDLE, ahead of both.
REQ-036 Reset mid-window: reset asserted in phase 1 of WIN_SYS.
- Response: next clock all outputs 0, din registers 8'hFF, no sys_ack.
- After release, SYS wins the first tie.
